// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Purpose  : Groups the fetch unit's control, memory and decode-side signals.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
   logic        Stall;
   logic        BranchTaken;
   logic [63:0] BranchTarget;
   logic        IMemReq;
   logic [63:0] IMemAddr;
   logic        IMemReady;
   logic [31:0] IMemData;
   logic [31:0] Instruction;
   logic [6:0]  Opcode;
   logic [63:0] PC_Out;
   logic        InstValid;
   logic        Halted;
   logic [15:0] FetchCount;

   modport master (
      input  Stall, BranchTaken, BranchTarget, IMemReady, IMemData,
      output IMemReq, IMemAddr, Instruction, Opcode, PC_Out, InstValid,
             Halted, FetchCount
   );

   modport slave (
      output Stall, BranchTaken, BranchTarget, IMemReady, IMemData,
      input  IMemReq, IMemAddr, Instruction, Opcode, PC_Out, InstValid,
             Halted, FetchCount
   );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Single-entry fetch stage with branch redirect and ECALL halt.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  wire logic          clk,
   input  wire logic          reset,
   instruction_fetch_if.master bus
);

   localparam logic [1:0]  c_boot  = 2'd0;
   localparam logic [1:0]  c_fetch = 2'd1;
   localparam logic [1:0]  c_halt  = 2'd2;
   localparam logic [31:0] c_ecall = 32'h0000_0073;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;
   logic [15:0] count_q, count_d;

   logic w_req;
   logic w_xfer;
   logic w_consume;

   assign w_req     = (state_q == c_fetch) && (!valid_q || !bus.Stall);
   assign w_xfer    = w_req && bus.IMemReady;
   assign w_consume = valid_q && !bus.Stall;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      count_d  = count_q;
      if (bus.BranchTaken) begin
         // Redirect wins over everything; a same-cycle transfer is dropped.
         state_d = c_fetch;
         pc_d    = bus.BranchTarget & ~64'h3;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            c_boot:  state_d = c_fetch;
            c_fetch: if (w_xfer && (bus.IMemData == c_ecall)) state_d = c_halt;
            c_halt:  state_d = c_halt;
            default: state_d = c_boot;
         endcase
         if (w_xfer) begin
            instr_d  = bus.IMemData;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 64'd4;
            count_d  = count_q + 16'd1;
         end else if (w_consume) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= c_boot;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0;
         pc_out_q <= 64'h0;
         valid_q  <= 1'b0;
         count_q  <= 16'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign bus.IMemReq     = w_req;
   assign bus.IMemAddr    = pc_q;
   assign bus.Instruction = instr_q;
   assign bus.Opcode      = instr_q[6:0];
   assign bus.PC_Out      = pc_out_q;
   assign bus.InstValid   = valid_q;
   assign bus.Halted      = (state_q == c_halt);
   assign bus.FetchCount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed vector bench for instruction_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   typedef struct {
      bit          rst;
      bit          stall;
      bit          br;
      bit          ready;
      logic [63:0] target;
      logic [31:0] data;
      bit          exp_req;
      logic [63:0] exp_addr;
      logic [31:0] exp_instr;
      logic [63:0] exp_pc;
      bit          exp_valid;
      bit          exp_halt;
      logic [15:0] exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl[$];

   instruction_fetch_if bus();

   instruction_fetch #(.RESET_PC(64'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit rst, input bit s, input bit b, input bit r,
                      input logic [63:0] t, input logic [31:0] d,
                      input bit ereq, input logic [63:0] ea,
                      input logic [31:0] ei, input logic [63:0] ep,
                      input bit ev, input bit eh, input logic [15:0] ec);
      vec_t v;
      v.rst = rst; v.stall = s; v.br = b; v.ready = r; v.target = t; v.data = d;
      v.exp_req = ereq; v.exp_addr = ea; v.exp_instr = ei; v.exp_pc = ep;
      v.exp_valid = ev; v.exp_halt = eh; v.exp_cnt = ec;
      tbl.push_back(v);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   {63'h0, bus.IMemReq},   64'h0);
      chk({tag, "_addr"},  bus.IMemAddr,           64'h0);
      chk({tag, "_instr"}, {32'h0, bus.Instruction}, 64'h0);
      chk({tag, "_opc"},   {57'h0, bus.Opcode},    64'h0);
      chk({tag, "_pcout"}, bus.PC_Out,             64'h0);
      chk({tag, "_valid"}, {63'h0, bus.InstValid}, 64'h0);
      chk({tag, "_halt"},  {63'h0, bus.Halted},    64'h0);
      chk({tag, "_cnt"},   {48'h0, bus.FetchCount}, 64'h0);
   endtask

   // Leaves the bench at posedge+1 with reset released; the next edge is BOOT.
   task automatic apply_reset();
      reset = 1'b0;
      #1;
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = 64'h0;
      bus.IMemReady = 1'b0; bus.IMemData = 32'h0;

      // Stream of four words, then a three-cycle stall.
      add(1,0,0,1,0,32'h33, 0,0,  32'h0,0,0,0,0);
      add(0,0,0,1,0,32'h33, 1,0,  32'h33,0,1,0,1);
      add(0,0,0,1,0,32'h03, 1,4,  32'h03,4,1,0,2);
      add(0,0,0,1,0,32'h23, 1,8,  32'h23,8,1,0,3);
      add(0,0,0,1,0,32'h63, 1,12, 32'h63,12,1,0,4);
      for (int i = 0; i < 3; i++) add(0,1,0,1,0,32'h13, 0,16, 32'h63,12,1,0,4);
      add(0,0,0,1,0,32'h13, 1,16, 32'h13,16,1,0,5);
      // Two memory wait states at PC=8.
      add(1,0,0,1,0,32'h33, 0,0, 32'h0,0,0,0,0);
      add(0,0,0,1,0,32'h33, 1,0, 32'h33,0,1,0,1);
      add(0,0,0,1,0,32'h03, 1,4, 32'h03,4,1,0,2);
      for (int i = 0; i < 2; i++) add(0,0,0,0,0,32'hDEADBEEF, 1,8, 32'h03,4,0,0,2);
      add(0,0,0,1,0,32'h23, 1,8, 32'h23,8,1,0,3);
      // Redirect colliding with a transfer from PC=16.
      add(1,0,0,1,0,32'h13, 0,0, 32'h0,0,0,0,0);
      for (int i = 0; i < 4; i++)
         add(0,0,0,1,0,32'h13, 1,64'(4*i), 32'h13,64'(4*i),1,0,16'(i+1));
      add(0,0,1,1,64'h103,32'h33, 1,16, 32'h13,12,0,0,4);
      add(0,0,0,0,0,32'h0, 1,64'h100, 32'h13,12,0,0,4);
      add(0,0,0,1,0,32'h93, 1,64'h100, 32'h93,64'h100,1,0,5);
      // ECALL at PC=20, then branch out of HALT.
      add(1,0,0,1,0,32'h13, 0,0, 32'h0,0,0,0,0);
      for (int i = 0; i < 5; i++)
         add(0,0,0,1,0,32'h13, 1,64'(4*i), 32'h13,64'(4*i),1,0,16'(i+1));
      add(0,0,0,1,0,32'h73, 1,20, 32'h73,20,1,1,6);
      add(0,1,0,1,0,32'h13, 0,24, 32'h73,20,1,1,6);
      add(0,0,0,1,0,32'h13, 0,24, 32'h73,20,0,1,6);
      add(0,0,0,1,0,32'h13, 0,24, 32'h73,20,0,1,6);
      add(0,0,1,1,64'h40,32'h13, 0,24, 32'h73,20,0,0,6);
      add(0,0,0,1,0,32'h13, 1,64'h40, 32'h13,64'h40,1,0,7);

      #1;
      foreach (tbl[k]) begin
         if (tbl[k].rst) apply_reset();
         bus.Stall = tbl[k].stall; bus.BranchTaken = tbl[k].br;
         bus.BranchTarget = tbl[k].target; bus.IMemReady = tbl[k].ready;
         bus.IMemData = tbl[k].data;
         #1;
         chk($sformatf("v%0d_req", k),  {63'h0, bus.IMemReq}, {63'h0, tbl[k].exp_req});
         chk($sformatf("v%0d_addr", k), bus.IMemAddr, tbl[k].exp_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_instr", k), {32'h0, bus.Instruction}, {32'h0, tbl[k].exp_instr});
         chk($sformatf("v%0d_opc", k),   {57'h0, bus.Opcode}, {57'h0, tbl[k].exp_instr[6:0]});
         chk($sformatf("v%0d_pcout", k), bus.PC_Out, tbl[k].exp_pc);
         chk($sformatf("v%0d_valid", k), {63'h0, bus.InstValid}, {63'h0, tbl[k].exp_valid});
         chk($sformatf("v%0d_halt", k),  {63'h0, bus.Halted}, {63'h0, tbl[k].exp_halt});
         chk($sformatf("v%0d_cnt", k),   {48'h0, bus.FetchCount}, {48'h0, tbl[k].exp_cnt});
      end

      // Asynchronous reset while a word is held under stall.
      bus.BranchTaken = 1'b0; bus.Stall = 1'b0; bus.IMemReady = 1'b1; bus.IMemData = 32'h33;
      apply_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ar_valid_pre", {63'h0, bus.InstValid}, 64'h1);
      bus.Stall = 1'b1;
      #1;
      chk("ar_req_stall", {63'h0, bus.IMemReq}, 64'h0);
      reset = 1'b0;
      #1;
      chk_reset_vals("ar_async");
      @(posedge clk); #1;
      chk_reset_vals("ar_held");
      reset = 1'b1;
      bus.Stall = 1'b0;
      #1;
      chk("ar_boot_req", {63'h0, bus.IMemReq}, 64'h0);
      @(posedge clk); #1;
      chk("ar_first_req", {63'h0, bus.IMemReq}, 64'h1);
      chk("ar_first_addr", bus.IMemAddr, 64'h0);
      @(posedge clk); #1;
      chk("ar_instr", {32'h0, bus.Instruction}, 64'h33);
      chk("ar_cnt", {48'h0, bus.FetchCount}, 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Stall  input  1  SHALL be the downstream hold: 1 = decode stage (Control_Unit side) not consuming.
REQ-005 BranchTaken  input  1  SHALL be the resolved-branch redirect strobe.
REQ-006 BranchTarget  input  64  SHALL be the redirect address.
REQ-007 IMemReq  output  1  SHALL be the instruction-memory read request.
REQ-008 IMemAddr  output  64  SHALL be the read address; it always equals the internal PC.
REQ-009 IMemReady  input  1  SHALL be memory ready; it is valid with IMemData in the same cycle.
REQ-010 IMemData  input  32  SHALL be the instruction word read from memory.
REQ-011 Instruction  output  32  SHALL be the registered fetched word.
REQ-012 Opcode  output  7  SHALL be Instruction[6:0], combinational; it feeds Control_Unit.Opcode.
REQ-013 PC_Out  output  64  SHALL be the address from which Instruction was fetched.
REQ-014 InstValid  output  1  SHALL be 1 while Instruction holds an unconsumed word.
REQ-015 Halted  output  1  SHALL be 1 while the FSM is in HALT.
REQ-016 FetchCount  output  16  SHALL count accepted fetches.

Function
REQ-017 FSM states SHALL be BOOT, FETCH and HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle with IMemReq=0 and then go to FETCH.
REQ-019 In FETCH, IMemReq SHALL be (!InstValid || !Stall); in BOOT and HALT, IMemReq SHALL be 0.
REQ-020 A transfer SHALL occur when IMemReq && IMemReady.
- On a transfer: Instruction<=IMemData, PC_Out<=PC, InstValid<=1, PC<=PC+4 (mod 2^64), FetchCount<=FetchCount+1.
- FetchCount SHALL wrap from 16'hFFFF to 0.
REQ-021 Consumption SHALL occur when InstValid && !Stall.
- Consumption without a same-cycle transfer SHALL clear InstValid.
- Consumption with a same-cycle transfer SHALL keep InstValid=1, so throughput is one instruction per cycle.
REQ-022 While InstValid && Stall: Instruction, PC_Out and InstValid SHALL hold, and IMemReq SHALL be 0.
REQ-023 IMemAddr SHALL stay stable while IMemReq=1 and IMemReady=0, so memory wait states are tolerated.
REQ-024 BranchTaken=1 SHALL take priority over transfer, Stall and FSM state:
- PC<={BranchTarget[63:2],2'b00} (the low two bits are ignored).
- InstValid<=0, and any same-cycle transfer is discarded (FetchCount is not incremented).
- The FSM goes to FETCH, including exit from HALT.
REQ-025 A transfer of IMemData==32'h00000073 (ECALL) SHALL be captured normally and move the FSM to HALT.
REQ-026 In HALT, the captured word SHALL remain consumable and no further requests SHALL issue.
- HALT exits only via BranchTaken or reset.
REQ-027 Latency: a word transferred in cycle N SHALL appear on Instruction/Opcode/PC_Out with InstValid=1 in cycle N+1.
REQ-028 The first request after reset SHALL assert in the second cycle after reset deassertion, with IMemAddr=RESET_PC.

Reset
REQ-029 Reset assertion SHALL immediately, without a clock, produce:
- PC=RESET_PC, Instruction=32'h0, PC_Out=0.
- InstValid=0, FetchCount=0, Halted=0, IMemReq=0, state=BOOT.
REQ-030 Reset asserted mid-transfer or mid-stall SHALL discard all in-flight state, with no partial update on the next clock edge.

Verification
REQ-031 Stream: RESET_PC=0, IMemReady=1, Stall=0, memory returns 0x00000033, 0x00000003, 0x00000023, 0x00000063.
- Required: Opcode sequence 0110011, 0000011, 0100011, 1100011 on consecutive cycles.
- Required: PC_Out 0, 4, 8, 12; FetchCount=4.
REQ-032 Stall: Stall=1 for 3 cycles while InstValid=1.
- Required: Instruction and PC_Out frozen, IMemReq=0.
- Required: after release, the next word arrives with PC_Out advanced by 4.
REQ-033 Wait states: IMemReady=0 for 2 cycles at PC=8.
- Required: IMemReq=1 and IMemAddr=8 held constant; InstValid=0 after the prior word is consumed; capture on the 3rd cycle.
REQ-034 Redirect: BranchTaken=1, BranchTarget=0x103 in the same cycle as a transfer from PC=16.
- Required: the transfer is discarded and InstValid=0 next cycle.
- Required: the next IMemAddr is 0x100; FetchCount is unchanged.
REQ-035 Halt: memory returns 0x00000073 at PC=20.
- Required: Halted=1 and IMemReq=0 thereafter; PC_Out=20 is consumable.
- Required: BranchTaken to 0x40 clears Halted, and a fetch at 0x40 follows.
REQ-036 Async reset: assert reset while Stall=1 and InstValid=1.
- Required: all outputs reach their reset values before the next clk edge.
- Required: after deassertion, the first request at RESET_PC comes one cycle after BOOT.
